// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response port and APB bus bundle for apb_master
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-word APB requester with wait-state timeout
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_master_if.master  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // wait_cnt counts completed ACCESS cycles, so the current cycle is wait_cnt + 1
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (int'(wait_cnt) == TIMEOUT_CYCLES - 1);
    assign bus.cmd_ready = (state == IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.PADDR       <= '0;
            bus.PWRITE      <= 1'b0;
            bus.PWDATA      <= '0;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.PADDR   <= bus.cmd_addr;
                        bus.PWRITE  <= bus.cmd_write;
                        bus.PWDATA  <= bus.cmd_write ? bus.cmd_wdata : '0;
                        bus.PSELx   <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        bus.PSELx       <= 1'b0;
                        bus.PENABLE     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
                        bus.rsp_err     <= bus.PSLVERR;
                        bus.rsp_timeout <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            bus.PSELx       <= 1'b0;
                            bus.PENABLE     <= 1'b0;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_rdata   <= '0;
                            bus.rsp_err     <= 1'b1;
                            bus.rsp_timeout <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-word commands from a local valid/ready port into APB SETUP/ACCESS transfers. It drives one APB slave, such as the team's zero-wait memory slave, and returns read data and error status on a one-cycle response pulse. It supports slave wait states via PREADY and aborts any transfer that exceeds a programmable wait-state limit. The block sits between test or firmware-model stimulus and the APB bus.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY; 0 disables the timeout
- PCLK  in  1  clock; all state changes on the rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by the timeout
- PADDR  out  ADDR_WIDTH  APB address
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready / wait state
- PSLVERR  in  1  APB slave error

## Operation
- FSM states are IDLE, SETUP and ACCESS. All outputs are registered except cmd_ready.
- cmd_ready = (state == IDLE). There is no command buffering, so a command must be held until accepted.
- **IDLE → SETUP** on accept:
  - Latch PADDR = cmd_addr and PWRITE = cmd_write.
  - Latch PWDATA = cmd_wdata for a write, or 0 for a read.
  - Drive PSELx = 1 and PENABLE = 0.
- **SETUP → ACCESS** unconditionally after one cycle:
  - Drive PENABLE = 1.
  - Clear the wait counter, which is wide enough to hold TIMEOUT_CYCLES.
- **ACCESS, PREADY = 1 at the edge**:
  - Go to IDLE and drive PSELx = 0, PENABLE = 0.
  - Assert rsp_valid = 1 for one cycle.
  - rsp_rdata = PRDATA for a read, or 0 for a write.
  - rsp_err = PSLVERR and rsp_timeout = 0.
- **ACCESS, PREADY = 0**:
  - Increment the wait counter.
  - If TIMEOUT_CYCLES ≠ 0 and this is ACCESS cycle number TIMEOUT_CYCLES, abort: go to IDLE, drop PSELx and PENABLE, and pulse rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- PADDR, PWRITE and PWDATA stay constant from SETUP through the end of ACCESS. They hold their last value in IDLE.
- PSLVERR and PRDATA are sampled only on the completing ACCESS edge and ignored otherwise.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next rsp_valid.
- cmd_* inputs are ignored when cmd_ready = 0.
- **Reset**:
  - All outputs go to 0 asynchronously and the state goes to IDLE.
  - A transfer in flight is dropped with no rsp_valid.
  - After PRESETn rises, cmd_ready is 1 in the first cycle.

## Timing
- The command is accepted at edge k:
  - k..k+1: SETUP.
  - From k+1: ACCESS.
  - With zero wait states, PREADY is seen at edge k+2 and rsp_valid is high for cycle k+2..k+3.
- Latency from accept to rsp_valid is 2 + W cycles, where W is the number of wait states.
- Minimum transfer spacing is 3 cycles. The IDLE cycle carrying rsp_valid can accept the next command, so the next SETUP starts at k+3.
- With timeout N, an unresponsive slave gives exactly N ACCESS cycles, and rsp_valid appears at accept + 1 + N.
- PSELx is never high for 2 consecutive transfers without an intervening IDLE cycle.
- PENABLE is high only while PSELx is high.

## Test plan
- **Write then read against the 1024-word slave:**
  - Stimulus: write addr 0x10, data 0xDEADBEEF, then read 0x10.
  - Required: write rsp_err = 0; read rsp_rdata = 0xDEADBEEF, rsp_err = 0.
  - Required: each rsp_valid arrives 2 cycles after accept, with PSELx/PENABLE showing 1/0 then 1/1.
- **Out-of-range read:**
  - Stimulus: read addr 0x400.
  - Required: rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- **Wait states:**
  - Stimulus: slave model holds PREADY = 0 for 3 ACCESS cycles, then returns 0x12345678.
  - Required: rsp_valid 5 cycles after accept; PADDR/PWDATA stable throughout; rsp_rdata = 0x12345678.
- **Timeout:**
  - Stimulus: PREADY stuck at 0, TIMEOUT_CYCLES = 16.
  - Required: exactly 16 ACCESS cycles, then rsp_err = 1, rsp_timeout = 1, and PSELx = 0 on the following cycle.
- **Reset mid-ACCESS:**
  - Stimulus: deassert PRESETn during ACCESS.
  - Required: PSELx, PENABLE and rsp_valid are 0 immediately; no response pulse after reset release; cmd_ready = 1.
- **Back-to-back commands:**
  - Stimulus: cmd_valid held high for 4 writes.
  - Required: accepts spaced exactly 3 cycles apart and 4 rsp_valid pulses in order.
